// File: rtl/decode_stage.sv
// Registered instruction decode stage with valid/ready handshakes, two-word
// (header + immediate) instructions, synchronous flush and a handshake counter.
module decode_stage #(
    parameter int unsigned         NUM_REGS   = 8,
    parameter int unsigned         INSTR_W    = 16,
    parameter int unsigned         COND_W     = 2,
    parameter int unsigned         OPC_W      = 4,
    parameter int unsigned         SHIFT_W    = 4,
    parameter logic [OPC_W-1:0]    IMM_OPCODE = 4'b1111,
    parameter int unsigned         CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INSTR_W-1:0]            in_instr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [COND_W-1:0]             out_cond,
    output logic [OPC_W-1:0]              out_opcode,
    output logic [$clog2(NUM_REGS)-1:0]   out_dest,
    output logic [$clog2(NUM_REGS)-1:0]   out_reg_1,
    output logic [$clog2(NUM_REGS)-1:0]   out_reg_2,
    output logic [SHIFT_W-1:0]            out_shift,
    output logic [NUM_REGS-1:0]           out_dest_en,
    output logic                          out_has_imm,
    output logic [INSTR_W-1:0]            out_imm,
    output logic [CNT_W-1:0]              decode_cnt
);

    localparam int unsigned REG_W    = $clog2(NUM_REGS);
    localparam int unsigned OPC_LSB  = INSTR_W - COND_W - OPC_W;
    localparam int unsigned DEST_LSB = OPC_LSB - REG_W;
    localparam int unsigned R1_LSB   = DEST_LSB - REG_W;
    localparam int unsigned R2_LSB   = R1_LSB - REG_W;

    typedef enum logic {S_HDR, S_IMM} state_t;

    state_t               r_state, w_state_nxt;
    logic [INSTR_W-1:0]   r_hold, w_hold_nxt;
    logic                 r_valid, w_valid_nxt;
    logic [COND_W-1:0]    r_cond, w_cond_nxt;
    logic [OPC_W-1:0]     r_opcode, w_opcode_nxt;
    logic [REG_W-1:0]     r_dest, w_dest_nxt;
    logic [REG_W-1:0]     r_reg_1, w_reg_1_nxt;
    logic [REG_W-1:0]     r_reg_2, w_reg_2_nxt;
    logic [SHIFT_W-1:0]   r_shift, w_shift_nxt;
    logic [NUM_REGS-1:0]  r_dest_en, w_dest_en_nxt;
    logic                 r_has_imm, w_has_imm_nxt;
    logic [INSTR_W-1:0]   r_imm, w_imm_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;

    logic                 w_in_fire;
    logic                 w_out_fire;
    logic [INSTR_W-1:0]   w_src;
    logic [OPC_W-1:0]     w_in_opc;

    assign in_ready   = !rst && !flush && (!r_valid || out_ready);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_valid && out_ready;
    // Fields come from the held header when the incoming word is its immediate.
    assign w_src      = (r_state == S_IMM) ? r_hold : in_instr;
    assign w_in_opc   = in_instr[OPC_LSB +: OPC_W];

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold;
        w_valid_nxt   = r_valid;
        w_cond_nxt    = r_cond;
        w_opcode_nxt  = r_opcode;
        w_dest_nxt    = r_dest;
        w_reg_1_nxt   = r_reg_1;
        w_reg_2_nxt   = r_reg_2;
        w_shift_nxt   = r_shift;
        w_dest_en_nxt = r_dest_en;
        w_has_imm_nxt = r_has_imm;
        w_imm_nxt     = r_imm;
        w_cnt_nxt     = r_cnt + CNT_W'(w_out_fire);

        if (flush) begin
            w_valid_nxt   = 1'b0;
            w_dest_en_nxt = '0;
            w_state_nxt   = S_HDR;
            w_hold_nxt    = '0;
        end else begin
            if (w_out_fire) begin
                w_valid_nxt   = 1'b0;
                w_dest_en_nxt = '0;
            end
            if (w_in_fire) begin
                if (r_state == S_HDR && w_in_opc == IMM_OPCODE) begin
                    w_hold_nxt  = in_instr;
                    w_state_nxt = S_IMM;
                end else begin
                    w_cond_nxt    = w_src[INSTR_W-1 -: COND_W];
                    w_opcode_nxt  = w_src[OPC_LSB +: OPC_W];
                    w_dest_nxt    = w_src[DEST_LSB +: REG_W];
                    w_reg_1_nxt   = w_src[R1_LSB +: REG_W];
                    w_reg_2_nxt   = w_src[R2_LSB +: REG_W];
                    w_shift_nxt   = w_src[SHIFT_W-1:0];
                    w_dest_en_nxt = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_src[DEST_LSB +: REG_W];
                    w_has_imm_nxt = (r_state == S_IMM);
                    w_imm_nxt     = (r_state == S_IMM) ? in_instr : '0;
                    w_valid_nxt   = 1'b1;
                    w_state_nxt   = S_HDR;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_HDR;
            r_hold    <= '0;
            r_valid   <= 1'b0;
            r_cond    <= '0;
            r_opcode  <= '0;
            r_dest    <= '0;
            r_reg_1   <= '0;
            r_reg_2   <= '0;
            r_shift   <= '0;
            r_dest_en <= '0;
            r_has_imm <= 1'b0;
            r_imm     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_hold    <= w_hold_nxt;
            r_valid   <= w_valid_nxt;
            r_cond    <= w_cond_nxt;
            r_opcode  <= w_opcode_nxt;
            r_dest    <= w_dest_nxt;
            r_reg_1   <= w_reg_1_nxt;
            r_reg_2   <= w_reg_2_nxt;
            r_shift   <= w_shift_nxt;
            r_dest_en <= w_dest_en_nxt;
            r_has_imm <= w_has_imm_nxt;
            r_imm     <= w_imm_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign out_valid   = r_valid;
    assign out_cond    = r_cond;
    assign out_opcode  = r_opcode;
    assign out_dest    = r_dest;
    assign out_reg_1   = r_reg_1;
    assign out_reg_2   = r_reg_2;
    assign out_shift   = r_shift;
    assign out_dest_en = r_dest_en;
    assign out_has_imm = r_has_imm;
    assign out_imm     = r_imm;
    assign decode_cnt  = r_cnt;

endmodule
